// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main + skid register with valid/ready handshake, flush and bubbles.
// Define STAGE_PERF_CNT_EN to add saturating stall/bubble performance counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
`ifdef STAGE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
`ifdef STAGE_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            state_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic              accept, emit;

    // Ready depends only on registered state, so no out_ready_i -> in_ready_o path.
    assign in_ready_o  = (state_q != StTwo);
    assign out_valid_o = (state_q != StEmpty);
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
    assign out_data_o  = main_data_q;
    assign occupancy_o = state_q;

    assign accept = in_valid_i & in_ready_o;
    assign emit   = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else if (flush_i) begin
            // Data registers are left alone; clearing ctrl is enough to kill the beats.
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q     <= StOne;
                        main_ctrl_q <= in_ctrl_i;
                        main_data_q <= in_data_i;
                    end
                end
                StOne: begin
                    if (accept && !emit) begin
                        state_q     <= StTwo;
                        skid_ctrl_q <= in_ctrl_i;
                        skid_data_q <= in_data_i;
                    end else if (accept) begin
                        main_ctrl_q <= in_ctrl_i;
                        main_data_q <= in_data_i;
                    end else if (emit) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    if (emit) begin
                        state_q     <= StOne;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

`ifdef STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!out_valid_o && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic vs a queue model.
module tb_pipe_stage_skid;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_ctrl_i;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_ctrl_o;
    logic [31:0] out_data_o;
    logic [1:0]  occupancy_o;
`ifdef STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_o, bubble_cnt_o;
    logic        in_ready_2, out_valid_2;
    logic [7:0]  out_ctrl_2;
    logic [31:0] out_data_2;
    logic [1:0]  occupancy_2;
    logic [1:0]  stall_cnt_2, bubble_cnt_2;
`endif

    always #5 clk_i = ~clk_i;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8)) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_o),
        .out_data_o  (out_data_o),
`ifdef STAGE_PERF_CNT_EN
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o),
`endif
        .occupancy_o (occupancy_o)
    );

`ifdef STAGE_PERF_CNT_EN
    // Narrow-counter copy to observe saturation.
    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CNT_W(2)) u_dut2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_2),
        .in_ctrl_i   (in_ctrl_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_2),
        .out_ready_i (out_ready_i),
        .out_ctrl_o  (out_ctrl_2),
        .out_data_o  (out_data_2),
        .stall_cnt_o (stall_cnt_2),
        .bubble_cnt_o(bubble_cnt_2),
        .occupancy_o (occupancy_2)
    );
`endif

    typedef struct {
        logic [7:0]  c;
        logic [31:0] d;
    } beat_t;

    beat_t q[$];
    longint stall_m, bubble_m;
    int total, bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic compare_all();
        chk("occupancy", 64'(occupancy_o), 64'(q.size()));
        chk("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_ctrl", 64'(out_ctrl_o), 64'(q[0].c));
            chk("out_data", 64'(out_data_o), 64'(q[0].d));
        end else begin
            chk("out_ctrl_idle", 64'(out_ctrl_o), 64'(0));
        end
`ifdef STAGE_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt_o), 64'(sat(stall_m, 64'hFFFF_FFFF)));
        chk("bubble_cnt", 64'(bubble_cnt_o), 64'(sat(bubble_m, 64'hFFFF_FFFF)));
        chk("stall_cnt_w2", 64'(stall_cnt_2), 64'(sat(stall_m, 3)));
        chk("bubble_cnt_w2", 64'(bubble_cnt_2), 64'(sat(bubble_m, 3)));
`endif
    endtask

    // Called at a falling edge: drive inputs, advance the model, check after the next rise.
    task automatic cyc(input logic v, input logic [7:0] c, input logic [31:0] d,
                       input logic rdy, input logic fl);
        beat_t b;
        bit acc, em;
        in_valid_i  = v;
        in_ctrl_i   = c;
        in_data_i   = d;
        out_ready_i = rdy;
        flush_i     = fl;
        acc = v && (q.size() < 2);
        em  = (q.size() != 0) && rdy;
        if (q.size() == 0) bubble_m++;
        else if (!rdy) stall_m++;
        if (fl) begin
            q.delete();
        end else begin
            if (em) void'(q.pop_front());
            if (acc) begin
                b.c = c;
                b.d = d;
                q.push_back(b);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
    endtask

    // Assert reset between edges, check the immediate effect, release on a falling edge.
    task automatic async_reset();
        #2;
        in_valid_i = 1'b1;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 64'(0));
        chk("arst_ctrl", 64'(out_ctrl_o), 64'(0));
        chk("arst_data", 64'(out_data_o), 64'(0));
        chk("arst_occ", 64'(occupancy_o), 64'(0));
        chk("arst_ready", 64'(in_ready_o), 64'(1));
        q.delete();
        stall_m  = 0;
        bubble_m = 0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        stall_m = 0;
        bubble_m = 0;
        rst_i = 1'b0;
        flush_i = 1'b0;
        in_valid_i = 1'b1;
        in_ctrl_i = 8'hFF;
        in_data_i = 32'hDEAD_BEEF;
        out_ready_i = 1'b0;
        #27;
        chk("rst_valid", 64'(out_valid_o), 64'(0));
        chk("rst_ctrl", 64'(out_ctrl_o), 64'(0));
        chk("rst_data", 64'(out_data_o), 64'(0));
        chk("rst_occ", 64'(occupancy_o), 64'(0));
        chk("rst_ready", 64'(in_ready_o), 64'(1));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Streaming at full rate
        cyc(1, 8'h11, 32'h1000, 1, 0);
        chk("stream0_data", 64'(out_data_o), 64'h1000);
        chk("stream0_ctrl", 64'(out_ctrl_o), 64'h11);
        cyc(1, 8'h22, 32'h1004, 1, 0);
        chk("stream1_data", 64'(out_data_o), 64'h1004);
        chk("stream1_occ", 64'(occupancy_o), 64'd1);
        cyc(1, 8'h33, 32'h1008, 1, 0);
        chk("stream2_data", 64'(out_data_o), 64'h1008);
        chk("stream2_ready", 64'(in_ready_o), 64'd1);
        cyc(0, 8'h00, 32'h0, 1, 0);
        chk("stream_drain_occ", 64'(occupancy_o), 64'd0);

        // Backpressure
        cyc(1, 8'h0A, 32'hA, 0, 0);
        chk("bp_occ1", 64'(occupancy_o), 64'd1);
        cyc(1, 8'h0B, 32'hB, 0, 0);
        chk("bp_occ2", 64'(occupancy_o), 64'd2);
        chk("bp_ready0", 64'(in_ready_o), 64'd0);
        cyc(1, 8'h0C, 32'hC, 0, 0);
        chk("bp_hold_data", 64'(out_data_o), 64'hA);
        cyc(1, 8'h0C, 32'hC, 1, 0);
        chk("bp_emitB", 64'(out_data_o), 64'hB);
        cyc(1, 8'h0C, 32'hC, 1, 0);
        chk("bp_emitC", 64'(out_data_o), 64'hC);
        cyc(0, 8'h00, 32'h0, 1, 0);
        chk("bp_empty", 64'(out_valid_o), 64'd0);

        // Flush with a beat offered in the same cycle
        cyc(1, 8'h0A, 32'hA, 0, 0);
        cyc(1, 8'h0B, 32'hB, 0, 0);
        cyc(1, 8'h0C, 32'hC, 0, 1);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl_o), 64'd0);
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        cyc(0, 8'h00, 32'h0, 1, 0);
        chk("flush_noC", 64'(out_valid_o), 64'd0);

        // Async reset while full
        cyc(1, 8'h0A, 32'hA, 0, 0);
        cyc(1, 8'h0B, 32'hB, 0, 0);
        async_reset();
        cyc(1, 8'h55, 32'h55, 1, 0);
        chk("post_rst_data", 64'(out_data_o), 64'h55);
        chk("post_rst_occ", 64'(occupancy_o), 64'd1);
        cyc(0, 8'h00, 32'h0, 1, 0);
        chk("post_rst_alone", 64'(out_valid_o), 64'd0);

        // Simultaneous accept and emit while holding one beat
        cyc(1, 8'h01, 32'h1, 1, 0);
        cyc(1, 8'h02, 32'h2, 1, 0);
        chk("sim_data", 64'(out_data_o), 64'h2);
        chk("sim_occ", 64'(occupancy_o), 64'd1);
        cyc(0, 8'h00, 32'h0, 1, 0);

`ifdef STAGE_PERF_CNT_EN
        // Counters: one empty cycle to load, 5 stalls, 1 emit, 3 bubbles
        async_reset();
        cyc(1, 8'h77, 32'h77, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 32'h0, 0, 0);
        cyc(0, 8'h00, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 32'h0, 1, 0);
        chk("perf_stall", 64'(stall_cnt_o), 64'd5);
        chk("perf_bubble", 64'(bubble_cnt_o), 64'd4);
        chk("perf_stall_sat", 64'(stall_cnt_2), 64'd3);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
